instr_encoder: RTL and testbench

Streaming RV64 instruction assembler. It is the inverse of the immediate sign-extension/decode path: it takes an opcode, register fields, funct3 and a 64-bit immediate, range-checks the immediate, and packs a 32-bit instruction word. It sits between the test/boot loader and instruction memory, and produces instruction words for the core to fetch. The block is a 2-stage valid/ready pipeline with error drop and statistics counters.

---
 rtl/instr_encoder.sv | 146 ++++++++++++++
 tb/tb_instr_encoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Streaming RV64 instruction assembler: packs opcode/register/immediate fields into a 32-bit word.
// Two-stage valid/ready pipeline; bad requests are dropped with a registered error pulse.
module instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [63:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             err_pulse,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] ok_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ERR_OPCODE = 2'd0;
  localparam logic [1:0] ERR_RANGE  = 2'd1;
  localparam logic [1:0] ERR_ALIGN  = 2'd2;

  logic        s1_valid;
  logic [6:0]  s1_opcode;
  logic [2:0]  s1_funct3;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [63:0] s1_imm;

  logic        known_op;
  logic        misalign;
  logic        range_bad;
  logic [31:0] word;
  logic        s1_err;
  logic [1:0]  s1_code;
  logic        s1_adv;

  // An immediate fits a field when every bit above its sign bit copies the sign bit.
  logic sext11, sext12, sext20, sext31;
  assign sext11 = (&s1_imm[63:11]) | ~(|s1_imm[63:11]);
  assign sext12 = (&s1_imm[63:12]) | ~(|s1_imm[63:12]);
  assign sext20 = (&s1_imm[63:20]) | ~(|s1_imm[63:20]);
  assign sext31 = (&s1_imm[63:31]) | ~(|s1_imm[63:31]);

  always_comb begin
    known_op  = 1'b1;
    misalign  = 1'b0;
    range_bad = 1'b0;
    word      = '0;
    case (s1_opcode)
      OP_IMM, OP_LOAD, OP_JALR: begin
        word      = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
        range_bad = !sext11;
      end
      OP_STORE: begin
        word      = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
        range_bad = !sext11;
      end
      OP_BRANCH: begin
        word      = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                     s1_imm[4:1], s1_imm[11], s1_opcode};
        range_bad = !sext12;
        misalign  = s1_imm[0];
      end
      OP_LUI: begin
        word      = {s1_imm[31:12], s1_rd, s1_opcode};
        range_bad = !sext31 || (s1_imm[11:0] != 12'd0);
      end
      OP_JAL: begin
        word      = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_opcode};
        range_bad = !sext20;
        misalign  = s1_imm[0];
      end
      default: known_op = 1'b0;
    endcase
  end

  assign s1_err  = !known_op || misalign || range_bad;
  assign s1_code = !known_op ? ERR_OPCODE : (misalign ? ERR_ALIGN : ERR_RANGE);

  // Errored entries never need S2, so they drain even under backpressure.
  assign s1_adv   = s1_valid && (s1_err || !out_valid || out_ready);
  assign in_ready = !reset && (!s1_valid || s1_adv);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_opcode <= '0;
      s1_funct3 <= '0;
      s1_rd     <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_imm    <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid  <= 1'b1;
      s1_opcode <= opcode;
      s1_funct3 <= funct3;
      s1_rd     <= rd;
      s1_rs1    <= rs1;
      s1_rs2    <= rs2;
      s1_imm    <= imm;
    end else if (s1_adv) begin
      s1_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      instr     <= '0;
      err_pulse <= 1'b0;
      err_code  <= '0;
      ok_count  <= '0;
      err_count <= '0;
    end else begin
      if (s1_adv && !s1_err) begin
        out_valid <= 1'b1;
        instr     <= word;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      err_pulse <= s1_adv && s1_err;
      if (s1_adv && s1_err) begin
        err_code <= s1_code;
        if (err_count != '1) err_count <= err_count + CNT_W'(1);
      end
      if (out_valid && out_ready && ok_count != '1) ok_count <= ok_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: vector table for encodings/errors, then
// saturation, backpressure/throughput and mid-stream reset sequences.
module tb_instr_encoder;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [63:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      instr;
  logic             err_pulse;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] ok_count;
  logic [CNT_W-1:0] err_count;

  instr_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
    .err_pulse(err_pulse), .err_code(err_code),
    .ok_count(ok_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic        is_err;
    logic [1:0]  code;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   failed = 0;
  int   ok_exp = 0;
  int   err_exp = 0;

  function automatic vec_t mk(string name, logic [6:0] op, logic [2:0] f3, logic [4:0] rd_v,
                              logic [4:0] rs1_v, logic [4:0] rs2_v, logic [63:0] imm_v,
                              logic is_err, logic [1:0] code, logic [31:0] word);
    vec_t v;
    v.name = name; v.op = op; v.f3 = f3; v.rd = rd_v; v.rs1 = rs1_v; v.rs2 = rs2_v;
    v.imm = imm_v; v.is_err = is_err; v.code = code; v.word = word;
    return v;
  endfunction

  function automatic int sat(int n);
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(vec_t v);
    opcode = v.op; funct3 = v.f3; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
    in_valid = 1'b1;
  endtask

  function automatic logic [31:0] addi_word(int k);
    return (32'(k) << 20) | (32'(k) << 7) | 32'h13;
  endfunction

  initial begin
    // Good encodings.
    vecs.push_back(mk("addi_m1",   7'h13, 3'd0, 5'd5,  5'd6, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 2'd0, 32'hFFF30293));
    vecs.push_back(mk("beq_8",     7'h63, 3'd0, 5'd0,  5'd1, 5'd2, 64'd8,                   0, 2'd0, 32'h00208463));
    vecs.push_back(mk("sd_16",     7'h23, 3'd3, 5'd0,  5'd2, 5'd3, 64'd16,                  0, 2'd0, 32'h00313823));
    vecs.push_back(mk("lui",       7'h37, 3'd0, 5'd10, 5'd0, 5'd0, 64'h1234_5000,          0, 2'd0, 32'h12345537));
    vecs.push_back(mk("jal_2048",  7'h6F, 3'd0, 5'd1,  5'd0, 5'd0, 64'd2048,                0, 2'd0, 32'h001000EF));
    vecs.push_back(mk("jal_m2",    7'h6F, 3'd0, 5'd0,  5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 2'd0, 32'hFFFFF06F));
    vecs.push_back(mk("bne_m4",    7'h63, 3'd1, 5'd0,  5'd3, 5'd4, 64'hFFFF_FFFF_FFFF_FFFC, 0, 2'd0, 32'hFE419EE3));
    vecs.push_back(mk("addi_2047", 7'h13, 3'd0, 5'd1,  5'd0, 5'd0, 64'd2047,                0, 2'd0, 32'h7FF00093));
    vecs.push_back(mk("addi_m2048",7'h13, 3'd0, 5'd0,  5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_F800, 0, 2'd0, 32'h80000013));
    vecs.push_back(mk("ld_8",      7'h03, 3'd3, 5'd7,  5'd2, 5'd0, 64'd8,                   0, 2'd0, 32'h00813383));
    vecs.push_back(mk("jalr_ret",  7'h67, 3'd0, 5'd0,  5'd1, 5'd0, 64'd0,                   0, 2'd0, 32'h00008067));
    vecs.push_back(mk("lui_m4096", 7'h37, 3'd0, 5'd1,  5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_F000, 0, 2'd0, 32'hFFFFF0B7));
    // Dropped requests.
    vecs.push_back(mk("addi_2048", 7'h13, 3'd0, 5'd5,  5'd6, 5'd0, 64'd2048,                1, 2'd1, 32'h0));
    vecs.push_back(mk("addi_m2049",7'h13, 3'd0, 5'd5,  5'd6, 5'd0, 64'hFFFF_FFFF_FFFF_F7FF, 1, 2'd1, 32'h0));
    vecs.push_back(mk("beq_7",     7'h63, 3'd0, 5'd0,  5'd1, 5'd2, 64'd7,                   1, 2'd2, 32'h0));
    vecs.push_back(mk("beq_4096",  7'h63, 3'd0, 5'd0,  5'd1, 5'd2, 64'd4096,                1, 2'd1, 32'h0));
    vecs.push_back(mk("beq_4097",  7'h63, 3'd0, 5'd0,  5'd1, 5'd2, 64'd4097,                1, 2'd2, 32'h0));
    vecs.push_back(mk("lui_lowbit",7'h37, 3'd0, 5'd1,  5'd0, 5'd0, 64'h800,                 1, 2'd1, 32'h0));
    vecs.push_back(mk("lui_2p31",  7'h37, 3'd0, 5'd1,  5'd0, 5'd0, 64'h8000_0000,           1, 2'd1, 32'h0));
    vecs.push_back(mk("jal_2p20",  7'h6F, 3'd0, 5'd1,  5'd0, 5'd0, 64'h10_0000,             1, 2'd1, 32'h0));
    vecs.push_back(mk("jal_3",     7'h6F, 3'd0, 5'd1,  5'd0, 5'd0, 64'd3,                   1, 2'd2, 32'h0));
    vecs.push_back(mk("op_7f",     7'h7F, 3'd0, 5'd1,  5'd0, 5'd0, 64'd0,                   1, 2'd0, 32'h0));
    vecs.push_back(mk("op_7f_odd", 7'h7F, 3'd0, 5'd1,  5'd0, 5'd0, 64'h1_0000_0001,         1, 2'd0, 32'h0));
    vecs.push_back(mk("op_rtype",  7'h33, 3'd0, 5'd1,  5'd2, 5'd3, 64'd0,                   1, 2'd0, 32'h0));

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; funct3 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    tick(); tick();
    checkOutput("reset_in_ready",  64'(in_ready),  64'd0);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_instr",     64'(instr),     64'd0);
    checkOutput("reset_err_pulse", 64'(err_pulse), 64'd0);
    checkOutput("reset_err_code",  64'(err_code),  64'd0);
    checkOutput("reset_ok_count",  64'(ok_count),  64'd0);
    checkOutput("reset_err_count", 64'(err_count), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", 64'(in_ready), 64'd1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      out_ready = 1'b1;
      #1;
      checkOutput({vecs[i].name, "_in_ready"}, 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      tick();
      checkOutput({vecs[i].name, "_out_valid"}, 64'(out_valid), 64'(!vecs[i].is_err));
      checkOutput({vecs[i].name, "_err_pulse"}, 64'(err_pulse), 64'(vecs[i].is_err));
      if (vecs[i].is_err) begin
        checkOutput({vecs[i].name, "_err_code"}, 64'(err_code), 64'(vecs[i].code));
        err_exp++;
      end else begin
        checkOutput({vecs[i].name, "_instr"}, 64'(instr), 64'(vecs[i].word));
        ok_exp++;
      end
      tick();
      checkOutput({vecs[i].name, "_out_valid_drop"}, 64'(out_valid), 64'd0);
      checkOutput({vecs[i].name, "_err_pulse_drop"}, 64'(err_pulse), 64'd0);
      checkOutput({vecs[i].name, "_ok_count"},  64'(ok_count),  64'(sat(ok_exp)));
      checkOutput({vecs[i].name, "_err_count"}, 64'(err_count), 64'(sat(err_exp)));
    end

    // Back-to-back unsupported opcodes: one drop per cycle, error counter saturates.
    begin
      int pulses = 0;
      applyStimulus(vecs[21]);
      out_ready = 1'b1;
      for (int i = 0; i < 24; i++) begin
        in_valid = (i < 20);
        tick();
        if (err_pulse) pulses++;
      end
      err_exp += 20;
      checkOutput("err_stream_pulses", 64'(pulses), 64'd20);
      checkOutput("err_count_sat", 64'(err_count), 64'(sat(err_exp)));
      checkOutput("err_stream_no_out", 64'(out_valid), 64'd0);
    end

    // Backpressure: four words against a stalled consumer, then release.
    begin
      int acc = 0;
      int rx = 0;
      int first_hs = -1;
      int last_hs = -1;
      for (int cyc = 0; cyc < 30; cyc++) begin
        if (cyc == 6) begin
          checkOutput("bp_accepted",   64'(acc),       64'd2);
          checkOutput("bp_in_ready",   64'(in_ready),  64'd0);
          checkOutput("bp_out_valid",  64'(out_valid), 64'd1);
          checkOutput("bp_instr_hold", 64'(instr),     64'(addi_word(1)));
        end
        out_ready = (cyc >= 6);
        in_valid  = (acc < 4);
        opcode = 7'h13; funct3 = 3'd0; rd = 5'(acc + 1); rs1 = 5'd0; rs2 = 5'd0;
        imm = 64'(acc + 1);
        #1;
        if (out_valid && out_ready) begin
          checkOutput("bp_order", 64'(instr), 64'(addi_word(rx + 1)));
          if (first_hs < 0) first_hs = cyc;
          last_hs = cyc;
          rx++;
        end
        if (in_valid && in_ready) acc++;
        tick();
      end
      ok_exp += 4;
      checkOutput("bp_words_out", 64'(rx), 64'd4);
      checkOutput("bp_back_to_back", 64'(last_hs - first_hs), 64'd3);
      checkOutput("ok_count_sat", 64'(ok_count), 64'(sat(ok_exp)));
    end

    // Reset with both stages full must flush everything.
    out_ready = 1'b0;
    applyStimulus(vecs[0]);
    tick(); tick();
    reset = 1'b1;
    tick();
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_ok_count",  64'(ok_count),  64'd0);
    checkOutput("midreset_err_count", 64'(err_count), 64'd0);
    checkOutput("midreset_in_ready",  64'(in_ready),  64'd0);
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    checkOutput("midreset_no_leak", 64'(out_valid), 64'd0);

    // Pipeline still works after the flush.
    applyStimulus(vecs[0]);
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("after_reset_out_valid", 64'(out_valid), 64'd1);
    checkOutput("after_reset_instr", 64'(instr), 64'h00000000_FFF30293);
    tick();
    checkOutput("after_reset_ok_count", 64'(ok_count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
